// File: rtl/ds_pkg.sv
// Shared types and helpers for the dispatch scheduler.
// Instruction class decode and FSM state encoding.
package ds_pkg;
  localparam int ALUOP_W = 9;
  localparam int CNT_W   = 5;

  typedef enum logic {
    DS_NORMAL,
    DS_SPLIT
  } ds_state_t;

  function automatic logic is_mem(
    input logic [ALUOP_W-1:0] aluop
  );
    return aluop[8];
  endfunction
endpackage

// File: rtl/ds_credit_cnt.sv
// Credit counter: consume/release per cycle, clamped at DEPTH.
// Overflow past the ceiling sets a sticky error cleared only by reset.
module ds_credit_cnt
  import ds_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic [1:0]       cons,
  input  logic [1:0]       rel,
  output logic [CNT_W-1:0] cnt,
  output logic             err
);
  localparam logic [CNT_W-1:0] CEIL = CNT_W'(DEPTH);

  logic [CNT_W-1:0] sum;
  logic             over;

  always_comb begin
    sum  = cnt - {3'b000, cons} + {3'b000, rel};
    over = (sum > CEIL);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= CEIL;
      err <= 1'b0;
    end else if (flush) begin
      cnt <= CEIL;
    end else begin
      cnt <= over ? CEIL : sum;
      if (over) err <= 1'b1;
    end
  end
endmodule

// File: rtl/ds_dispatch_ctrl.sv
// In-order dual dispatch to ALU/MEM issue queues with ROB allocation.
// Drives the DS register stall and supports split dispatch of a pair.
module ds_dispatch_ctrl
  import ds_pkg::*;
#(
  parameter int ALU_IQ_DEPTH = 8,
  parameter int MEM_IQ_DEPTH = 4,
  parameter int ROB_DEPTH    = 16,
  parameter int ROB_AW       = $clog2(ROB_DEPTH)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic               ds_inst1_valid,
  input  logic [ALUOP_W-1:0] ds_inst1_aluop,
  input  logic               ds_inst2_valid,
  input  logic [ALUOP_W-1:0] ds_inst2_aluop,
  input  logic [1:0]         alu_iq_release,
  input  logic [1:0]         mem_iq_release,
  input  logic [1:0]         rob_commit,
  output logic               stall,
  output logic               disp1_valid,
  output logic               disp1_is_mem,
  output logic [ROB_AW-1:0]  disp1_rob_idx,
  output logic               disp2_valid,
  output logic               disp2_is_mem,
  output logic [ROB_AW-1:0]  disp2_rob_idx,
  output logic               credit_err
);
  ds_state_t state, state_nx;

  logic [CNT_W-1:0]  alu_cr, mem_cr, rob_free;
  logic [CNT_W-1:0]  q1, q2;
  logic [ROB_AW-1:0] rob_tail, idx2;
  logic [1:0]        alu_c, mem_c, rob_c;
  logic [1:0]        alu_r, mem_r, rob_r;
  logic              alu_e, mem_e, rob_e;
  logic              m1, m2, split, same;
  logic              ok1, ok2, d1, d2, done1, done2;

  always_comb begin
    m1    = is_mem(ds_inst1_aluop);
    m2    = is_mem(ds_inst2_aluop);
    split = (state == DS_SPLIT);
    q1    = m1 ? mem_cr : alu_cr;
    q2    = m2 ? mem_cr : alu_cr;
    ok1   = (rob_free >= 5'd1) && (q1 >= 5'd1);
    d1    = !flush && !split && ds_inst1_valid && ok1;
    // slot 2 must see what slot 1 took this cycle
    same  = d1 && (m1 == m2);
    ok2   = (rob_free >= (5'd1 + {4'b0, d1}))
         && (q2 >= (5'd1 + {4'b0, same}));
    d2    = !flush && (split || d1 || !ds_inst1_valid)
         && ds_inst2_valid && ok2;
    done1 = split || !ds_inst1_valid || d1;
    done2 = !ds_inst2_valid || d2;
    stall = !flush && !(done1 && done2);

    state_nx = DS_NORMAL;
    if (!flush && !(done1 && done2) && (d1 || split))
      state_nx = DS_SPLIT;

    alu_c = {1'b0, d1 && !m1} + {1'b0, d2 && !m2};
    mem_c = {1'b0, d1 && m1} + {1'b0, d2 && m2};
    rob_c = {1'b0, d1} + {1'b0, d2};
    alu_r = flush ? 2'd0 : alu_iq_release;
    mem_r = flush ? 2'd0 : mem_iq_release;
    rob_r = flush ? 2'd0 : rob_commit;
    idx2  = rob_tail + ROB_AW'(d1);
  end

  ds_credit_cnt #(.DEPTH(ALU_IQ_DEPTH)) u_alu (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .cons(alu_c), .rel(alu_r),
    .cnt(alu_cr), .err(alu_e)
  );

  ds_credit_cnt #(.DEPTH(MEM_IQ_DEPTH)) u_mem (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .cons(mem_c), .rel(mem_r),
    .cnt(mem_cr), .err(mem_e)
  );

  ds_credit_cnt #(.DEPTH(ROB_DEPTH)) u_rob (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .cons(rob_c), .rel(rob_r),
    .cnt(rob_free), .err(rob_e)
  );

  assign credit_err = alu_e | mem_e | rob_e;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= DS_NORMAL;
      rob_tail      <= '0;
      disp1_valid   <= 1'b0;
      disp1_is_mem  <= 1'b0;
      disp1_rob_idx <= '0;
      disp2_valid   <= 1'b0;
      disp2_is_mem  <= 1'b0;
      disp2_rob_idx <= '0;
    end else if (flush) begin
      state         <= DS_NORMAL;
      rob_tail      <= '0;
      disp1_valid   <= 1'b0;
      disp1_is_mem  <= 1'b0;
      disp1_rob_idx <= '0;
      disp2_valid   <= 1'b0;
      disp2_is_mem  <= 1'b0;
      disp2_rob_idx <= '0;
    end else begin
      state         <= state_nx;
      rob_tail      <= rob_tail + ROB_AW'(d1) + ROB_AW'(d2);
      disp1_valid   <= d1;
      disp1_is_mem  <= d1 & m1;
      disp1_rob_idx <= d1 ? rob_tail : '0;
      disp2_valid   <= d2;
      disp2_is_mem  <= d2 & m2;
      disp2_rob_idx <= d2 ? idx2 : '0;
    end
  end
endmodule

// File: tb/tb_ds_dispatch_ctrl.sv
// Randomized scoreboard bench for ds_dispatch_ctrl.
// Reference model dispatches pending slots greedily in program order.
module tb_ds_dispatch_ctrl;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       flush = 1'b0;
  logic       v1 = 1'b0, v2 = 1'b0;
  logic [8:0] op1 = '0, op2 = '0;
  logic [1:0] ar = '0, mr = '0, rc = '0;
  logic       stall, d1v, d1m, d2v, d2m, cerr;
  logic [3:0] d1i, d2i;

  ds_dispatch_ctrl dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .ds_inst1_valid(v1), .ds_inst1_aluop(op1),
    .ds_inst2_valid(v2), .ds_inst2_aluop(op2),
    .alu_iq_release(ar), .mem_iq_release(mr),
    .rob_commit(rc), .stall(stall),
    .disp1_valid(d1v), .disp1_is_mem(d1m),
    .disp1_rob_idx(d1i),
    .disp2_valid(d2v), .disp2_is_mem(d2m),
    .disp2_rob_idx(d2i),
    .credit_err(cerr)
  );

  always #5 clk = ~clk;

  typedef struct {
    int cyc;
    bit v1, m1, v2, m2;
    int i1, i2;
  } exp_t;

  exp_t q[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;

  int alu_cr = 8, mem_cr = 4, rob_free = 16, tail = 0;
  bit sent1 = 0, err = 0, mstall = 0;

  always @(posedge clk) cyc = cyc + 1;

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] expv);
    vectors++;
    if (act !== expv) begin
      miscompares++;
      $display("FAIL %s: got %0d want %0d (cycle %0d)",
               name, act, expv, cyc);
    end
  endtask

  function automatic int upd(input int cur, input int rel,
                             input int ceil, inout bit e);
    int n = cur + rel;
    if (n > ceil) begin
      n = ceil;
      e = 1'b1;
    end
    return n;
  endfunction

  task automatic step(input bit fl,
                      input bit a_v1, input logic [8:0] a_op1,
                      input bit a_v2, input logic [8:0] a_op2,
                      input logic [1:0] a_ar, input logic [1:0] a_mr,
                      input logic [1:0] a_rc);
    int   ra, rm, rr, t;
    bit   blk, m1, m2;
    exp_t e;
    @(posedge clk);
    #1;
    flush = fl; v1 = a_v1; op1 = a_op1; v2 = a_v2; op2 = a_op2;
    ar = a_ar; mr = a_mr; rc = a_rc;
    #1;
    check("credit_err", {31'b0, cerr}, {31'b0, err});
    if (fl) begin
      check("stall_flush", {31'b0, stall}, 32'd0);
      alu_cr = 8; mem_cr = 4; rob_free = 16; tail = 0;
      sent1 = 0; mstall = 0;
      return;
    end
    ra = alu_cr; rm = mem_cr; rr = rob_free; t = tail; blk = 0;
    m1 = a_op1[8]; m2 = a_op2[8];
    e = '{default: 0};
    e.cyc = cyc + 1;
    if (a_v1 && !sent1) begin
      if (rr >= 1 && (m1 ? rm : ra) >= 1) begin
        rr--;
        if (m1) rm--; else ra--;
        e.v1 = 1; e.m1 = m1; e.i1 = t; t = (t + 1) % 16;
      end else blk = 1;
    end
    if (a_v2 && !blk) begin
      if (rr >= 1 && (m2 ? rm : ra) >= 1) begin
        rr--;
        if (m2) rm--; else ra--;
        e.v2 = 1; e.m2 = m2; e.i2 = t; t = (t + 1) % 16;
      end else blk = 1;
    end
    check("stall", {31'b0, stall}, {31'b0, blk});
    if (e.v1 || e.v2) q.push_back(e);
    alu_cr   = upd(ra, int'(a_ar), 8, err);
    mem_cr   = upd(rm, int'(a_mr), 4, err);
    rob_free = upd(rr, int'(a_rc), 16, err);
    tail  = t;
    sent1 = blk ? (sent1 | e.v1) : 1'b0;
    mstall = blk;
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      while (q.size() > 0 && q[0].cyc < cyc) begin
        vectors++; miscompares++;
        $display("FAIL missing_dispatch: got none want cycle %0d",
                 q[0].cyc);
        void'(q.pop_front());
      end
      if (d1v || d2v) begin
        if (q.size() == 0 || q[0].cyc != cyc) begin
          vectors++; miscompares++;
          $display("FAIL unexpected_dispatch: got v1=%0d v2=%0d want none (cycle %0d)",
                   d1v, d2v, cyc);
        end else begin
          exp_t e;
          e = q.pop_front();
          check("disp1_valid", {31'b0, d1v}, {31'b0, e.v1});
          check("disp2_valid", {31'b0, d2v}, {31'b0, e.v2});
          if (e.v1) begin
            check("disp1_is_mem", {31'b0, d1m}, {31'b0, e.m1});
            check("disp1_rob_idx", {28'b0, d1i}, e.i1);
          end
          if (e.v2) begin
            check("disp2_is_mem", {31'b0, d2m}, {31'b0, e.m2});
            check("disp2_rob_idx", {28'b0, d2i}, e.i2);
          end
        end
      end
    end
  end

  function automatic logic [1:0] pick(input int occ, input int pct);
    int lim = (occ < 2) ? occ : 2;
    if ($urandom_range(0, 99) < pct)
      return 2'($urandom_range(0, lim));
    return 2'd0;
  endfunction

  initial begin
    bit         hv1, hv2, fl;
    logic [8:0] h1, h2;
    v1 = 1; v2 = 1;
    op1 = 9'h001; op2 = 9'h002;
    repeat (3) begin
      @(negedge clk);
      check("rst_stall", {31'b0, stall}, 32'd0);
      check("rst_disp1_valid", {31'b0, d1v}, 32'd0);
      check("rst_disp2_valid", {31'b0, d2v}, 32'd0);
      check("rst_credit_err", {31'b0, cerr}, 32'd0);
    end
    @(posedge clk);
    #1;
    v1 = 0; v2 = 0;
    rst_n = 1;

    step(0, 1, 9'h001, 1, 9'h002, 0, 0, 0);
    step(0, 1, 9'h003, 1, 9'h104, 0, 0, 0);
    step(0, 0, 9'h000, 0, 9'h000, 0, 0, 0);

    hv1 = 0; hv2 = 0; h1 = '0; h2 = '0;
    repeat (3000) begin
      if (!mstall) begin
        hv1 = ($urandom_range(0, 99) < 85);
        hv2 = ($urandom_range(0, 99) < 85);
        h1  = 9'($urandom);
        h2  = 9'($urandom);
      end
      fl = ($urandom_range(0, 59) == 0);
      step(fl, hv1, h1, hv2, h2,
           pick(8 - alu_cr, 45),
           pick(4 - mem_cr, 40),
           pick(16 - rob_free, 30));
    end

    step(1, 0, 9'h000, 0, 9'h000, 0, 0, 0);
    step(0, 0, 9'h000, 0, 9'h000, 2, 0, 0);
    step(0, 0, 9'h000, 0, 9'h000, 0, 0, 0);
    step(1, 0, 9'h000, 0, 9'h000, 0, 0, 0);
    step(0, 1, 9'h005, 1, 9'h106, 0, 0, 0);
    step(0, 0, 9'h000, 0, 9'h000, 0, 0, 0);
    step(0, 0, 9'h000, 0, 9'h000, 0, 0, 0);
    check("err_sticky", {31'b0, cerr}, 32'd1);
    check("queue_drained", q.size(), 32'd0);

    @(posedge clk);
    #1;
    rst_n = 0;
    #1;
    check("err_cleared", {31'b0, cerr}, 32'd0);
    check("rst2_disp1_valid", {31'b0, d1v}, 32'd0);
    check("rst2_disp2_valid", {31'b0, d2v}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end
endmodule
